// File: rtl/mem_arb_pkg.sv
// Shared definitions for the round-robin memory arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / BUSY0 / BUSY1)
//   NDIR_DEF    : default address MSB index (address is NDIR+1 bits wide)
//   DW_DEF      : default data width
//   BEAT_W      : width of the burst beat counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } arb_state_t;

  localparam int NDIR_DEF = 2;
  localparam int DW_DEF   = 32;
  localparam int BEAT_W   = 4;

endpackage

// File: rtl/mem_arbiter_rr_burst_cnt.sv
// burst_cnt: saturating beat counter for the arbiter.
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : clear to 0 (wins over inc)
//   inc  : increment by one, holding at MAX_BURST-1
//   beat : current count
//   tc   : terminal count, high when beat == MAX_BURST-1
module burst_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [BEAT_W-1:0] beat,
  output logic              tc
);

  localparam logic [BEAT_W-1:0] TC_VAL = BEAT_W'(MAX_BURST - 1);

  assign tc = (beat == TC_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (clr) begin
      beat <= '0;
    end else if (inc && !tc) begin
      beat <= beat + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one memory port between two
// requesters, with a burst cap so a waiting requester is never starved.
//
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   REQ0/1                  level request, one access per granted cycle
//   DIR0/1, LE0/1, DATO_W0/1 per-requester address, write strobe, write data
//   GNT0/1                  grant (decoded from the state register)
//   ACK0/1                  registered, one cycle after each access
//   DATO_R                  registered read data, valid with ACK0/ACK1
//   MEM_DIR/LE/DATO_W       memory-side address, write strobe, write data
//   MEM_DATO_R              memory read data (combinational from MEM_DIR)
//   dbg_state, dbg_beat     FSM state and beat count for observation
//
// Handshake: a requester holds REQx high for as long as it wants accesses.
// An access happens in every cycle where GNTx=1 and REQx=1; the matching
// ACKx pulse (with DATO_R for reads) appears exactly one cycle later.
// Dropping REQx ends the grant without an access in that cycle.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NDIR      = NDIR_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4,
  parameter int PWR_ID    = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [NDIR:0]     DIR0,
  input  logic [NDIR:0]     DIR1,
  input  logic              LE0,
  input  logic              LE1,
  input  logic [DW-1:0]     DATO_W0,
  input  logic [DW-1:0]     DATO_W1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DW-1:0]     DATO_R,
  output logic [NDIR:0]     MEM_DIR,
  output logic              MEM_LE,
  output logic [DW-1:0]     MEM_DATO_W,
  input  logic [DW-1:0]     MEM_DATO_R,
  output logic [1:0]        dbg_state,
  output logic [BEAT_W-1:0] dbg_beat
);

  // PWR_ID only selects a power-counter slot elsewhere; it is checked here
  // alongside the burst range so bad instances fail at elaboration.
  if (MAX_BURST < 1 || MAX_BURST > 15 || PWR_ID < 0) begin : g_bad_param
    $error("mem_arbiter_rr: illegal parameter value");
  end

  arb_state_t        state;
  logic              last;
  logic              acc0, acc1;
  logic              cnt_clr, cnt_inc, cnt_tc;
  logic [BEAT_W-1:0] beat;

  assign GNT0      = (state == BUSY0);
  assign GNT1      = (state == BUSY1);
  assign acc0      = GNT0 && REQ0;
  assign acc1      = GNT1 && REQ1;
  assign dbg_state = state;
  assign dbg_beat  = beat;

  // Memory mux: idle drives an all-zero, non-writing bus.
  always_comb begin
    MEM_DIR    = '0;
    MEM_LE     = 1'b0;
    MEM_DATO_W = '0;
    if (GNT0) begin
      MEM_DIR    = DIR0;
      MEM_LE     = LE0 & REQ0;
      MEM_DATO_W = DATO_W0;
    end else if (GNT1) begin
      MEM_DIR    = DIR1;
      MEM_LE     = LE1 & REQ1;
      MEM_DATO_W = DATO_W1;
    end
  end

  // Beat control: clear whenever the grant leaves the current owner,
  // otherwise count accesses (the counter saturates on its own, which keeps
  // a lone requester granted indefinitely).
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (GNT0) begin
      if (!REQ0 || (REQ1 && cnt_tc)) cnt_clr = 1'b1;
      else                           cnt_inc = 1'b1;
    end else if (GNT1) begin
      if (!REQ1 || (REQ0 && cnt_tc)) cnt_clr = 1'b1;
      else                           cnt_inc = 1'b1;
    end
  end

  burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clk  (CLK),
    .rst  (RESET),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .beat (beat),
    .tc   (cnt_tc)
  );

  // last records the requester that most recently held the grant; on a
  // simultaneous request from IDLE the other one wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      last   <= 1'b1;
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      DATO_R <= '0;
    end else begin
      ACK0 <= acc0;
      ACK1 <= acc1;
      if (acc0 || acc1) DATO_R <= MEM_DATO_R;
      case (state)
        IDLE: begin
          if (REQ0 && REQ1) state <= last ? BUSY0 : BUSY1;
          else if (REQ0)    state <= BUSY0;
          else if (REQ1)    state <= BUSY1;
        end
        BUSY0: begin
          if (!REQ0) begin
            state <= REQ1 ? BUSY1 : IDLE;
            last  <= 1'b0;
          end else if (REQ1 && cnt_tc) begin
            state <= BUSY1;
            last  <= 1'b0;
          end
        end
        BUSY1: begin
          if (!REQ1) begin
            state <= REQ0 ? BUSY0 : IDLE;
            last  <= 1'b1;
          end else if (REQ0 && cnt_tc) begin
            state <= BUSY0;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Testbench for mem_arbiter_rr: directed scenarios followed by randomized
// request traffic, checked against a behavioural arbitration model and a
// scoreboard of expected acknowledges.
module tb_mem_arbiter_rr;

  localparam int NDIR = 2;
  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int AW   = NDIR + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0, req1, le0, le1;
  logic [AW-1:0] dir0, dir1;
  logic [DW-1:0] dw0, dw1;
  logic          gnt0, gnt1, ack0, ack1, mem_le;
  logic [DW-1:0] dato_r, mem_dato_w, mem_dato_r;
  logic [AW-1:0] mem_dir;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_beat;

  mem_arbiter_rr #(.NDIR(NDIR), .DW(DW), .MAX_BURST(MAXB), .PWR_ID(0)) dut (
    .CLK(clk), .RESET(rst),
    .REQ0(req0), .REQ1(req1), .DIR0(dir0), .DIR1(dir1),
    .LE0(le0), .LE1(le1), .DATO_W0(dw0), .DATO_W1(dw1),
    .GNT0(gnt0), .GNT1(gnt1), .ACK0(ack0), .ACK1(ack1), .DATO_R(dato_r),
    .MEM_DIR(mem_dir), .MEM_LE(mem_le), .MEM_DATO_W(mem_dato_w),
    .MEM_DATO_R(mem_dato_r), .dbg_state(dbg_state), .dbg_beat(dbg_beat)
  );

  // Memory attached to the arbiter's memory port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign mem_dato_r = mem[mem_dir];
  always @(posedge clk) if (mem_le) mem[mem_dir] <= mem_dato_w;

  // ---------------- scoreboard ----------------
  // entry: {is_write, requester, read data}
  logic [DW+1:0] exp_q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected entry for every acknowledge the DUT shows.
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL ack_unexpected: got ack1/ack0=%b%b expected none at %0t", ack1, ack0, $time);
      end else begin
        e = exp_q.pop_front();
        check("ack_id", {62'd0, ack1, ack0}, e[DW] ? 64'd2 : 64'd1);
        if (!e[DW+1]) check("rd_data", {32'd0, dato_r}, {32'd0, e[DW-1:0]});
      end
    end
  end

  // ---------------- reference model ----------------
  // owner: -1 nobody granted, 0/1 the granted requester.
  // run:   accesses already made in the current grant (capped at MAXB-1).
  // prev:  requester that last held the grant (decides ties).
  int            m_owner = -1;
  int            m_run = 0;
  int            m_prev = 1;
  bit            m_known = 0;
  bit            m_after_reset = 0;
  logic [1:0]    m_ack = 2'b00;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  task automatic run_cycle();
    int            x;
    bit            rq [2];
    bit            acc, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    x = m_owner;
    rq[0] = req0;
    rq[1] = req1;
    a  = (x == 1) ? dir1 : dir0;
    d  = (x == 1) ? dw1 : dw0;
    wr = (x == 1) ? le1 : le0;
    acc = (x >= 0) && rq[x] && !rst;
    if (acc) exp_q.push_back({wr, x[0], wr ? {DW{1'b0}} : ref_mem[a]});

    @(negedge clk);
    if (m_known) begin
      check("grant", {62'd0, gnt1, gnt0}, {62'd0, x == 1, x == 0});
      check("state", {62'd0, dbg_state}, (x < 0) ? 64'd0 : ((x == 0) ? 64'd1 : 64'd2));
      check("beat", {60'd0, dbg_beat}, 64'(m_run));
      check("ack_timing", {62'd0, ack1, ack0}, {62'd0, m_ack});
      if (x < 0) check("mem_bus", {28'd0, mem_le, mem_dir, mem_dato_w}, 64'd0);
      else check("mem_bus", {28'd0, mem_le, mem_dir, mem_dato_w},
                 {28'd0, wr & rq[x], a, d});
    end
    if (m_after_reset) check("reset_out", {31'd0, ack0, ack1, dato_r}, 64'd0);

    @(posedge clk);
    // the memory port writes whenever the bus strobe is up, even under reset
    if (x >= 0 && rq[x] && wr) ref_mem[a] = d;
    m_ack = acc ? ((x == 0) ? 2'b01 : 2'b10) : 2'b00;
    if (rst) begin
      m_owner = -1; m_run = 0; m_prev = 1;
      m_known = 1; m_after_reset = 1;
    end else begin
      m_after_reset = 0;
      if (x < 0) begin
        if (rq[0] && rq[1]) m_owner = 1 - m_prev;
        else if (rq[0])     m_owner = 0;
        else if (rq[1])     m_owner = 1;
      end else if (!rq[x]) begin
        m_owner = rq[1-x] ? 1 - x : -1;
        m_run = 0; m_prev = x;
      end else if (rq[1-x] && m_run == MAXB - 1) begin
        m_owner = 1 - x;
        m_run = 0; m_prev = x;
      end else if (m_run < MAXB - 1) begin
        m_run++;
      end
    end
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic rand_data();
    dir0 = AW'($urandom_range(0, (1 << AW) - 1));
    dir1 = AW'($urandom_range(0, (1 << AW) - 1));
    le0  = 1'($urandom_range(0, 1));
    le1  = 1'($urandom_range(0, 1));
    dw0  = $urandom;
    dw1  = $urandom;
  endtask

  task automatic step(input bit r, input bit r0, input bit r1, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r; req0 = r0; req1 = r1;
      rand_data();
      run_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    rand_data();
    #1;

    // reset with both requests held, then release: requester 0 wins first
    step(1, 1, 1, 3);
    step(0, 1, 1, 3);
    step(0, 0, 0, 2);

    // write DEADBEEF to address 3, then read it back
    rst = 0; req0 = 1; req1 = 0; le0 = 1; dir0 = 3'd3; dw0 = 32'hDEADBEEF;
    run_cycle();
    run_cycle();
    le0 = 0; dw0 = $urandom;
    run_cycle();
    step(0, 0, 0, 3);

    // both held: alternating full bursts
    step(0, 1, 1, 20);
    step(0, 0, 0, 2);

    // requester 0 drops mid-burst with requester 1 waiting
    step(0, 1, 0, 1);
    step(0, 1, 1, 2);
    step(0, 0, 1, 6);
    step(0, 1, 1, 6);
    step(0, 0, 0, 2);

    // requester 1 alone keeps the grant
    step(0, 0, 1, 11);
    step(0, 0, 0, 2);

    // reset lands on the second access of a burst
    step(0, 1, 0, 2);
    step(1, 1, 0, 1);
    step(0, 1, 0, 4);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      rst = ($urandom_range(0, 199) == 0);
      rand_data();
      run_cycle();
    end

    step(0, 0, 0, 3);
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
